// File: rtl/key_gear_ctrl.sv
// Driver-key front end: debounced keys, gear-shift FSM with a timed clutch phase and over-rev downshift guard.
// Optional macro KEYGEAR_AUTO_DOWNSHIFT_EN adds a standstill auto-downshift to gear 1.
module key_gear_ctrl #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int SHIFT_TICKS    = 3,
    parameter int GEAR_MAX       = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1khz,
    input  logic       tick_10hz,
    input  logic       key_throttle_raw,
    input  logic       key_brake_raw,
    input  logic       key_up_raw,
    input  logic       key_down_raw,
    input  logic [8:0] speed_kmh,
    output logic       throttle,
    output logic       brake,
    output logic [2:0] gear,
    output logic       shifting,
    output logic       shift_denied
);

    localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic {IDLE, CLUTCH} state_t;

    logic [3:0] key_raw;
    logic [3:0] stable;
    logic [3:0] stable_prev_q;

    // Bit order: 0 throttle, 1 brake, 2 up, 3 down.
    assign key_raw = {key_down_raw, key_up_raw, key_brake_raw, key_throttle_raw};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            logic           sync1_q;
            logic           sync2_q;
            logic           stable_q;
            logic [DBW-1:0] cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q  <= 1'b0;
                    sync2_q  <= 1'b0;
                    stable_q <= 1'b0;
                    cnt_q    <= '0;
                end else begin
                    sync1_q <= key_raw[gi];
                    sync2_q <= sync1_q;
                    if (tick_1khz) begin
                        if (sync2_q == stable_q) begin
                            cnt_q <= '0;
                        end else if (cnt_q == DBW'(DEBOUNCE_TICKS - 1)) begin
                            stable_q <= ~stable_q;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + DBW'(1);
                        end
                    end
                end
            end

            assign stable[gi] = stable_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_prev_q <= '0;
        end else begin
            stable_prev_q <= stable;
        end
    end

    logic up_press;
    logic down_press;

    assign up_press   = stable[2] & ~stable_prev_q[2];
    assign down_press = stable[3] & ~stable_prev_q[3];

    function automatic logic [8:0] gear_ceiling(input logic [2:0] g);
        case (g)
            3'd1:    gear_ceiling = 9'd30;
            3'd2:    gear_ceiling = 9'd70;
            3'd3:    gear_ceiling = 9'd130;
            3'd4:    gear_ceiling = 9'd200;
            3'd5:    gear_ceiling = 9'd300;
            3'd6:    gear_ceiling = 9'd400;
            default: gear_ceiling = 9'd511;
        endcase
    endfunction

    state_t     state_q;
    logic [2:0] gear_q;
    logic [2:0] target_q;
    logic [3:0] tick_cnt_q;
    logic       shifting_q;
    logic       denied_q;

    logic [2:0] gear_dn;
    logic       start_shift;
    logic [2:0] start_target;
    logic       deny;

    assign gear_dn = gear_q - 3'd1;

    // Shift decision in IDLE; speed is judged only in the press cycle.
    always_comb begin
        start_shift  = 1'b0;
        start_target = gear_q;
        deny         = 1'b0;
        if (state_q == IDLE) begin
            if (up_press && down_press) begin
                deny = 1'b1;
            end else if (up_press) begin
                if (gear_q < 3'(GEAR_MAX)) begin
                    start_shift  = 1'b1;
                    start_target = gear_q + 3'd1;
                end else begin
                    deny = 1'b1;
                end
            end else if (down_press) begin
                if (gear_q == 3'd0) begin
                    deny = 1'b1;
                end else if (gear_q == 3'd1 || speed_kmh <= gear_ceiling(gear_dn)) begin
                    start_shift  = 1'b1;
                    start_target = gear_dn;
                end else begin
                    deny = 1'b1;
                end
            end
`ifdef KEYGEAR_AUTO_DOWNSHIFT_EN
            else if (tick_10hz && gear_q >= 3'd2 && speed_kmh == 9'd0 && !throttle) begin
                start_shift  = 1'b1;
                start_target = 3'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gear_q     <= 3'd0;
            target_q   <= 3'd0;
            tick_cnt_q <= 4'd0;
            shifting_q <= 1'b0;
            denied_q   <= 1'b0;
        end else begin
            denied_q <= deny;
            case (state_q)
                IDLE: begin
                    if (start_shift) begin
                        state_q    <= CLUTCH;
                        target_q   <= start_target;
                        tick_cnt_q <= 4'd0;
                        shifting_q <= 1'b1;
                    end
                end
                CLUTCH: begin
                    if (tick_10hz) begin
                        if (tick_cnt_q == 4'(SHIFT_TICKS - 1)) begin
                            gear_q     <= target_q;
                            shifting_q <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gear         = gear_q;
    assign shifting     = shifting_q;
    assign shift_denied = denied_q;
    assign brake        = stable[1];
    assign throttle     = stable[0] & ~stable[1] & ~shifting_q;

endmodule

// File: tb/tb_key_gear_ctrl.sv
// Self-checking bench for key_gear_ctrl: vector table, randomized presses against a gear model, corner sequences.
module tb_key_gear_ctrl;

    localparam int DT = 4;
    localparam int ST = 2;
    localparam int GM = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1khz = 1'b0;
    logic       tick_10hz = 1'b0;
    logic       key_throttle_raw = 1'b0;
    logic       key_brake_raw = 1'b0;
    logic       key_up_raw = 1'b0;
    logic       key_down_raw = 1'b0;
    logic [8:0] speed_kmh = 9'd5;
    logic       throttle;
    logic       brake;
    logic [2:0] gear;
    logic       shifting;
    logic       shift_denied;

    key_gear_ctrl #(.DEBOUNCE_TICKS(DT), .SHIFT_TICKS(ST), .GEAR_MAX(GM)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1khz(tick_1khz), .tick_10hz(tick_10hz),
        .key_throttle_raw(key_throttle_raw), .key_brake_raw(key_brake_raw),
        .key_up_raw(key_up_raw), .key_down_raw(key_down_raw), .speed_kmh(speed_kmh),
        .throttle(throttle), .brake(brake), .gear(gear), .shifting(shifting),
        .shift_denied(shift_denied)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            tick_1khz = (cyc % 4 == 0);
            tick_10hz = (cyc % 25 == 0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    int ceil_tab[7] = '{0, 30, 70, 130, 200, 300, 400};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic do_press(input bit up, input bit dn, input int spd,
                            output int denied, output int deny_len, output int shift_ticks,
                            output int thr_bad, output int shifted, output int timed_out);
        int n;
        denied = 0; deny_len = 0; shift_ticks = 0; thr_bad = 0; shifted = 0; timed_out = 0;
        speed_kmh = 9'(spd);
        key_up_raw = up;
        key_down_raw = dn;
        n = 0;
        while (!shift_denied && !shifting && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (shift_denied) begin
            denied = 1;
            while (shift_denied && deny_len < 5) begin
                deny_len++;
                @(negedge clk);
            end
        end else if (shifting) begin
            shifted = 1;
            n = 0;
            while (shifting && n < 300) begin
                if (tick_10hz) shift_ticks++;
                if (throttle) thr_bad++;
                @(negedge clk);
                n++;
            end
            if (shifting) timed_out = 1;
        end else begin
            timed_out = 1;
        end
        key_up_raw = 1'b0;
        key_down_raw = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    typedef struct {
        bit up;
        bit dn;
        int spd;
        int exp_gear;
        int exp_deny;
    } vec_t;

    vec_t tbl[13];
    int   gear_m;

    initial begin
        int denied, deny_len, sticks, thr_bad, shifted, tout, n, lat, seen, dcnt, pre;
        bit up, dn, first_up;
        int spd, cmd, exp_deny;

        tbl[0]  = '{1, 0, 5,   1, 0};
        tbl[1]  = '{1, 0, 5,   2, 0};
        tbl[2]  = '{1, 0, 5,   3, 0};
        tbl[3]  = '{1, 0, 5,   4, 0};
        tbl[4]  = '{1, 0, 5,   5, 0};
        tbl[5]  = '{1, 0, 5,   6, 0};
        tbl[6]  = '{1, 0, 5,   6, 1};
        tbl[7]  = '{0, 1, 300, 5, 0};
        tbl[8]  = '{0, 1, 200, 4, 0};
        tbl[9]  = '{0, 1, 130, 3, 0};
        tbl[10] = '{0, 1, 71,  3, 1};
        tbl[11] = '{0, 1, 70,  2, 0};
        tbl[12] = '{1, 1, 5,   2, 1};

        // Reset
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_gear", int'(gear), 0);
        check("reset_throttle", int'(throttle), 0);
        check("reset_brake", int'(brake), 0);
        check("reset_shifting", int'(shifting), 0);
        check("reset_denied", int'(shift_denied), 0);

        // Debounce: bouncing throttle, then steady
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            key_throttle_raw = ~key_throttle_raw;
            repeat (8) begin
                @(negedge clk);
                if (throttle) seen++;
            end
        end
        check("bounce_throttle_stays_low", seen, 0);
        key_throttle_raw = 1'b1;
        lat = 0;
        while (!throttle && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("debounce_latency_in_window", int'(lat >= 14 && lat <= 19), 1);
        repeat (10) @(negedge clk);

        // Vector table: upshift chain, limit, over-rev, simultaneous
        for (int i = 0; i < 13; i++) begin
            do_press(tbl[i].up, tbl[i].dn, tbl[i].spd, denied, deny_len, sticks, thr_bad, shifted, tout);
            check($sformatf("vec%0d_timeout", i), tout, 0);
            check($sformatf("vec%0d_gear", i), int'(gear), tbl[i].exp_gear);
            check($sformatf("vec%0d_denied", i), denied, tbl[i].exp_deny);
            if (tbl[i].exp_deny != 0) begin
                check($sformatf("vec%0d_deny_len", i), deny_len, 1);
            end else begin
                check($sformatf("vec%0d_shift_ticks", i), sticks, ST);
                check($sformatf("vec%0d_thr_in_clutch", i), thr_bad, 0);
            end
        end
        gear_m = 2;

        // Randomized presses against the gear model
        for (int i = 0; i < 25; i++) begin
            cmd = int'($urandom_range(0, 9));
            up = (cmd < 5) || (cmd == 9);
            dn = (cmd >= 5);
            if (gear_m >= 2 && $urandom_range(0, 1) == 1)
                spd = ceil_tab[gear_m - 1] + int'($urandom_range(0, 2)) - 1;
            else
                spd = int'($urandom_range(1, 450));
            exp_deny = 0;
            if (up && dn) exp_deny = 1;
            else if (up) begin
                if (gear_m < GM) gear_m++;
                else exp_deny = 1;
            end else begin
                if (gear_m == 0) exp_deny = 1;
                else if (gear_m == 1) gear_m = 0;
                else if (spd <= ceil_tab[gear_m - 1]) gear_m--;
                else exp_deny = 1;
            end
            do_press(up, dn, spd, denied, deny_len, sticks, thr_bad, shifted, tout);
            check($sformatf("rnd%0d_up%0d_dn%0d_spd%0d_gear", i, up, dn, spd), int'(gear), gear_m);
            check($sformatf("rnd%0d_denied", i), denied, exp_deny);
        end

        // Throttle and brake together
        speed_kmh = 9'd5;
        key_brake_raw = 1'b1;
        repeat (40) @(negedge clk);
        check("tb_both_throttle", int'(throttle), 0);
        check("tb_both_brake", int'(brake), 1);
        key_brake_raw = 1'b0;
        repeat (40) @(negedge clk);
        check("brake_released_throttle", int'(throttle), 1);

        // Press during CLUTCH is discarded silently
        first_up = (gear_m < GM);
        speed_kmh = 9'd5;
        key_up_raw = first_up;
        key_down_raw = !first_up;
        n = 0;
        while (!shifting && n < 80) begin @(negedge clk); n++; end
        check("midclutch_entered", int'(shifting), 1);
        key_up_raw = !first_up;
        key_down_raw = first_up;
        dcnt = 0; n = 0;
        while (shifting && n < 300) begin
            if (shift_denied) dcnt++;
            @(negedge clk);
            n++;
        end
        gear_m = first_up ? gear_m + 1 : gear_m - 1;
        check("midclutch_gear", int'(gear), gear_m);
        key_up_raw = 1'b0;
        key_down_raw = 1'b0;
        repeat (60) begin
            if (shift_denied || shifting) dcnt++;
            @(negedge clk);
        end
        check("midclutch_no_deny_no_shift", dcnt, 0);
        check("midclutch_gear_held", int'(gear), gear_m);

        // Asynchronous reset mid-CLUTCH
        if (gear_m == 0) begin
            do_press(1, 0, 5, denied, deny_len, sticks, thr_bad, shifted, tout);
            gear_m = 1;
            check("pre_reset_gear", int'(gear), 1);
        end
        key_down_raw = 1'b1;
        speed_kmh = 9'd5;
        n = 0;
        while (!shifting && n < 80) begin @(negedge clk); n++; end
        check("reset_clutch_entered", int'(shifting), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_gear", int'(gear), 0);
        check("async_reset_shifting", int'(shifting), 0);
        key_down_raw = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        gear_m = 0;
        repeat (2) @(negedge clk);
        check("post_reset_throttle", int'(throttle), 0);
        check("post_reset_gear", int'(gear), 0);
        repeat (40) @(negedge clk);

        // Standstill with gear 4 and no throttle
        for (int i = 0; i < 4; i++) do_press(1, 0, 5, denied, deny_len, sticks, thr_bad, shifted, tout);
        check("auto_setup_gear", int'(gear), 4);
        key_throttle_raw = 1'b0;
        repeat (40) @(negedge clk);
        speed_kmh = 9'd0;
`ifdef KEYGEAR_AUTO_DOWNSHIFT_EN
        pre = 0; n = 0;
        while (!shifting && n < 200) begin
            if (tick_10hz) pre++;
            @(negedge clk);
            n++;
        end
        check("auto_entered", int'(shifting), 1);
        check("auto_entry_ticks", pre, 1);
        sticks = 0; dcnt = 0; n = 0;
        while (shifting && n < 300) begin
            if (tick_10hz) sticks++;
            if (shift_denied) dcnt++;
            @(negedge clk);
            n++;
        end
        check("auto_clutch_ticks", sticks, ST);
        check("auto_gear", int'(gear), 1);
        repeat (100) begin
            if (shift_denied) dcnt++;
            @(negedge clk);
        end
        check("auto_no_deny", dcnt, 0);
        check("auto_gear_held", int'(gear), 1);
`else
        pre = 0;
        repeat (100) begin
            if (shifting || shift_denied) pre++;
            @(negedge clk);
        end
        check("no_auto_activity", pre, 0);
        check("no_auto_gear", int'(gear), 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
